// File: rtl/fetch_pc_gen_if.sv
// Fetch-side bundle: instruction memory port, predictor answer, execute resolution and IF/ID outputs.
// Latency: none; this is wiring only.
// Backpressure: stall travels with the bundle; execute redirects are never held off.
interface fetch_pc_gen_if;
  logic        stall;
  logic [31:0] imem_addr;
  logic [31:0] imem_inst;
  logic        pred_taken;
  logic        ex_valid;
  logic        ex_is_cf;
  logic [31:0] ex_pc;
  logic        ex_taken;
  logic [31:0] ex_target;
  logic        ex_mispredict;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        if_pred_taken;
  logic [31:0] if_pred_target;

  // fetch unit side
  modport master (
    input  stall, imem_inst, pred_taken,
    input  ex_valid, ex_is_cf, ex_pc, ex_taken, ex_target, ex_mispredict,
    output imem_addr, if_valid, if_pc, if_inst, if_pred_taken, if_pred_target
  );

  // decode / execute / memory side
  modport slave (
    output stall, imem_inst, pred_taken,
    output ex_valid, ex_is_cf, ex_pc, ex_taken, ex_target, ex_mispredict,
    input  imem_addr, if_valid, if_pc, if_inst, if_pred_taken, if_pred_target
  );
endinterface

// File: rtl/fetch_pc_gen.sv
// Fetch PC generator with direct-mapped BTB and IF/ID register; build option BTB_EN enables the BTB.
// Latency: imem_addr is the PC register; IF/ID shows the fetched word next cycle; redirect lands after one edge.
// Backpressure: stall holds PC and IF/ID; an execute redirect overrides stall; BTB writes ignore stall.
module fetch_pc_gen #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BTB_IDX_W = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  fetch_pc_gen_if.master bus
);
  localparam logic [31:0] NOP     = 32'h0000_0013;
  localparam logic [31:0] PC_INIT = {RESET_PC[31:2], 2'b00};

  logic [31:0] pc_q;
  logic [31:0] pc_d;
  logic [31:0] pc_plus4;
  logic [31:0] redirect_pc;
  logic        redirect;
  logic        pt;
  logic [31:0] pt_target;
  logic        if_valid_q;
  logic [31:0] if_pc_q;
  logic [31:0] if_inst_q;

  assign pc_plus4    = pc_q + 32'd4;
  assign redirect    = bus.ex_valid & bus.ex_mispredict;
  // low address bits are forced to zero so the PC stays word aligned
  assign redirect_pc = bus.ex_taken ? {bus.ex_target[31:2], 2'b00}
                                    : ({bus.ex_pc[31:2], 2'b00} + 32'd4);

`ifdef BTB_EN
  localparam int BTB_N = 1 << BTB_IDX_W;
  localparam int TAG_W = 30 - BTB_IDX_W;

  logic [4:0]           opc;
  logic                 is_br;
  logic                 is_jal;
  logic                 is_jalr;
  logic [BTB_N-1:0]     btb_vld;
  logic [TAG_W-1:0]     btb_tag [BTB_N];
  logic [29:0]          btb_tgt [BTB_N];
  logic [BTB_IDX_W-1:0] lkp_idx;
  logic [TAG_W-1:0]     lkp_tag;
  logic [BTB_IDX_W-1:0] upd_idx;
  logic                 btb_hit;
  logic                 btb_wr;
  logic                 if_pt_q;
  logic [31:0]          if_tgt_q;
  logic                 unused_bits;

  assign opc     = bus.imem_inst[6:2];
  assign is_br   = (opc == 5'b11000);
  assign is_jal  = (opc == 5'b11011);
  assign is_jalr = (opc == 5'b11001);

  assign lkp_idx = pc_q[BTB_IDX_W+1:2];
  assign lkp_tag = pc_q[31:BTB_IDX_W+2];
  assign upd_idx = bus.ex_pc[BTB_IDX_W+1:2];

  // lookup reads pre-edge contents, so a same-cycle write to this index is not seen yet
  assign btb_hit   = btb_vld[lkp_idx] && (btb_tag[lkp_idx] == lkp_tag);
  assign pt        = btb_hit && (is_jal || is_jalr || (is_br && bus.pred_taken));
  assign pt_target = {btb_tgt[lkp_idx], 2'b00};

  // only taken resolutions allocate; not-taken is left to the direction predictor
  assign btb_wr = bus.ex_valid & bus.ex_is_cf & bus.ex_taken;

  assign unused_bits = ^{bus.imem_inst[31:7], bus.imem_inst[1:0],
                         bus.ex_target[1:0], bus.ex_pc[1:0]};

  // valid bits: cleared by reset, set by each taken resolution
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btb_vld <= '0;
    end else if (btb_wr) begin
      btb_vld[upd_idx] <= 1'b1;
    end
  end

  // tag and target payload, only meaningful where the valid bit is set
  always_ff @(posedge clk) begin
    if (btb_wr) begin
      btb_tag[upd_idx] <= bus.ex_pc[31:BTB_IDX_W+2];
      btb_tgt[upd_idx] <= bus.ex_target[31:2];
    end
  end

  // prediction fields of IF/ID follow the same load/bubble/hold rules as the rest
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_pt_q  <= 1'b0;
      if_tgt_q <= 32'h0;
    end else if (redirect) begin
      if_pt_q  <= 1'b0;
      if_tgt_q <= 32'h0;
    end else if (!bus.stall) begin
      if_pt_q  <= pt;
      if_tgt_q <= pt ? pt_target : 32'h0;
    end
  end

  assign bus.if_pred_taken  = if_pt_q;
  assign bus.if_pred_target = if_tgt_q;
`else
  logic [BTB_IDX_W-1:0] unused_idx;
  logic                 unused_bits;

  assign pt                 = 1'b0;
  assign pt_target          = 32'h0;
  assign bus.if_pred_taken  = 1'b0;
  assign bus.if_pred_target = 32'h0;
  assign unused_idx         = bus.ex_pc[BTB_IDX_W+1:2];
  assign unused_bits        = ^{bus.imem_inst, bus.pred_taken, bus.ex_is_cf,
                                bus.ex_target[1:0], bus.ex_pc[1:0]};
`endif

  // next PC: redirect first, then stall hold, then BTB prediction, then sequential
  always_comb begin
    pc_d = pc_q;
    if (redirect) begin
      pc_d = redirect_pc;
    end else if (!bus.stall) begin
      pc_d = pt ? pt_target : pc_plus4;
    end
  end

  // PC register drives the instruction memory directly
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= PC_INIT;
    end else begin
      pc_q <= pc_d;
    end
  end

  // IF/ID register: bubble on redirect, hold on stall, otherwise capture the fetch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_valid_q <= 1'b0;
      if_pc_q    <= 32'h0;
      if_inst_q  <= NOP;
    end else if (redirect) begin
      if_valid_q <= 1'b0;
      if_pc_q    <= 32'h0;
      if_inst_q  <= NOP;
    end else if (!bus.stall) begin
      if_valid_q <= 1'b1;
      if_pc_q    <= pc_q;
      if_inst_q  <= bus.imem_inst;
    end
  end

  assign bus.imem_addr = pc_q;
  assign bus.if_valid  = if_valid_q;
  assign bus.if_pc     = if_pc_q;
  assign bus.if_inst   = if_inst_q;
endmodule

// File: tb/tb_fetch_pc_gen.sv
// Bench for fetch_pc_gen: directed scenarios plus randomized traffic against a behavioural model.
// Latency: one clock per step; outputs are sampled 1ns after the rising edge.
// Backpressure: stall and redirects are driven by the bench; the model follows the same priorities.
module tb_fetch_pc_gen;
  localparam logic [31:0] RST_PC = 32'h0000_0100;
  localparam int          IDXW   = 4;
`ifdef BTB_EN
  localparam bit BTB_ON = 1'b1;
`else
  localparam bit BTB_ON = 1'b0;
`endif
  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] BR   = 32'h0000_0063;
  localparam logic [31:0] JAL  = 32'h0000_006F;
  localparam logic [31:0] JALR = 32'h0000_0067;

  logic clk;
  logic rst_n;
  fetch_pc_gen_if bus();

  fetch_pc_gen #(.RESET_PC(RST_PC), .BTB_IDX_W(IDXW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int errors;

  // behavioural model state
  logic [31:0] m_pc, m_ifpc, m_inst, m_tgt;
  logic        m_vld, m_pt;
  logic [31:0] btb_src [int];
  logic [31:0] btb_dst [int];

  function automatic int idx_of(input logic [31:0] a);
    return int'((a >> 2) % (32'd1 << IDXW));
  endfunction

  function automatic logic model_pt(input logic [31:0] pc, input logic [31:0] inst, input logic ptk);
    logic [4:0] op;
    int         i;
    op = inst[6:2];
    i  = idx_of(pc);
    if (!BTB_ON) return 1'b0;
    if (!btb_src.exists(i)) return 1'b0;
    if ((btb_src[i] >> (IDXW + 2)) != (pc >> (IDXW + 2))) return 1'b0;
    return (op == 5'b11011) || (op == 5'b11001) || ((op == 5'b11000) && ptk);
  endfunction

  task automatic model_reset();
    m_pc = RST_PC; m_ifpc = 32'h0; m_inst = NOP; m_tgt = 32'h0; m_vld = 1'b0; m_pt = 1'b0;
    btb_src.delete();
    btb_dst.delete();
  endtask

  // one clock: apply fetch-side inputs, advance the model, return 1ns after the edge
  task automatic step(input logic st, input logic [31:0] inst, input logic ptk);
    logic        p;
    logic [31:0] t;
    logic [31:0] n_pc;
    bus.stall = st; bus.imem_inst = inst; bus.pred_taken = ptk;
    p    = model_pt(m_pc, inst, ptk);
    t    = p ? (btb_dst[idx_of(m_pc)] & 32'hFFFF_FFFC) : 32'h0;
    n_pc = m_pc;
    if (bus.ex_valid && bus.ex_mispredict) begin
      n_pc = bus.ex_taken ? (bus.ex_target & 32'hFFFF_FFFC) : (bus.ex_pc + 32'd4);
      m_vld = 1'b0; m_inst = NOP; m_pt = 1'b0; m_tgt = 32'h0;
    end else if (!st) begin
      m_vld = 1'b1; m_ifpc = m_pc; m_inst = inst; m_pt = p; m_tgt = t;
      n_pc = p ? t : (m_pc + 32'd4);
    end
    if (BTB_ON && bus.ex_valid && bus.ex_is_cf && bus.ex_taken) begin
      btb_src[idx_of(bus.ex_pc)] = bus.ex_pc;
      btb_dst[idx_of(bus.ex_pc)] = bus.ex_target;
    end
    @(posedge clk); #1;
    m_pc = n_pc;
    bus.ex_valid = 1'b0; bus.ex_mispredict = 1'b0; bus.ex_is_cf = 1'b0; bus.ex_taken = 1'b0;
  endtask

  task automatic redirect_to(input logic [31:0] a);
    bus.ex_valid = 1'b1; bus.ex_mispredict = 1'b1; bus.ex_is_cf = 1'b0;
    bus.ex_taken = 1'b1; bus.ex_target = a; bus.ex_pc = 32'h0;
    step(1'b0, NOP, 1'b0);
  endtask

  task automatic train(input logic [31:0] pc, input logic [31:0] tgt, input logic taken);
    bus.ex_valid = 1'b1; bus.ex_mispredict = 1'b0; bus.ex_is_cf = 1'b1;
    bus.ex_taken = taken; bus.ex_pc = pc; bus.ex_target = tgt;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus.imem_addr !== 32'h100) begin errors++; $display("FAIL reset_addr got=%h exp=%h", bus.imem_addr, 32'h100); end
    checks++; if (bus.if_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", bus.if_valid); end
    checks++; if (bus.if_pc !== 32'h0) begin errors++; $display("FAIL reset_ifpc got=%h exp=0", bus.if_pc); end
    checks++; if (bus.if_inst !== NOP) begin errors++; $display("FAIL reset_inst got=%h exp=%h", bus.if_inst, NOP); end
    checks++; if (bus.if_pred_taken !== 1'b0) begin errors++; $display("FAIL reset_pt got=%b exp=0", bus.if_pred_taken); end
    checks++; if (bus.if_pred_target !== 32'h0) begin errors++; $display("FAIL reset_ptgt got=%h exp=0", bus.if_pred_target); end
    rst_n = 1'b1;
    step(1'b0, NOP, 1'b0);
    checks++; if (bus.imem_addr !== 32'h104) begin errors++; $display("FAIL seq_addr1 got=%h exp=%h", bus.imem_addr, 32'h104); end
    checks++; if (bus.if_valid !== 1'b1) begin errors++; $display("FAIL seq_valid got=%b exp=1", bus.if_valid); end
    checks++; if (bus.if_pc !== 32'h100) begin errors++; $display("FAIL seq_ifpc got=%h exp=%h", bus.if_pc, 32'h100); end
    step(1'b0, 32'h0040_0093, 1'b0);
    checks++; if (bus.imem_addr !== 32'h108) begin errors++; $display("FAIL seq_addr2 got=%h exp=%h", bus.imem_addr, 32'h108); end
    checks++; if (bus.if_inst !== 32'h0040_0093) begin errors++; $display("FAIL seq_inst got=%h exp=%h", bus.if_inst, 32'h0040_0093); end
  endtask

  task automatic test_redirect();
    bus.ex_valid = 1'b1; bus.ex_mispredict = 1'b1; bus.ex_is_cf = 1'b0;
    bus.ex_taken = 1'b1; bus.ex_target = 32'h2003; bus.ex_pc = 32'h500;
    step(1'b1, NOP, 1'b0);
    checks++; if (bus.imem_addr !== 32'h2000) begin errors++; $display("FAIL redir_addr got=%h exp=%h", bus.imem_addr, 32'h2000); end
    checks++; if (bus.if_valid !== 1'b0) begin errors++; $display("FAIL redir_bubble got=%b exp=0", bus.if_valid); end
    checks++; if (bus.if_inst !== NOP) begin errors++; $display("FAIL redir_inst got=%h exp=%h", bus.if_inst, NOP); end
    bus.ex_valid = 1'b1; bus.ex_mispredict = 1'b1; bus.ex_taken = 1'b0; bus.ex_pc = 32'h300;
    step(1'b0, NOP, 1'b0);
    checks++; if (bus.imem_addr !== 32'h304) begin errors++; $display("FAIL redir_nt got=%h exp=%h", bus.imem_addr, 32'h304); end
  endtask

  task automatic test_btb();
    train(32'h40, 32'h80, 1'b1);
    step(1'b0, NOP, 1'b0);
    redirect_to(32'h40);
    step(1'b0, BR, 1'b1);
    checks++; if (bus.imem_addr !== (BTB_ON ? 32'h80 : 32'h44)) begin errors++; $display("FAIL btb_br_taken got=%h exp=%h", bus.imem_addr, (BTB_ON ? 32'h80 : 32'h44)); end
    checks++; if (bus.if_pred_taken !== BTB_ON) begin errors++; $display("FAIL btb_if_pt got=%b exp=%b", bus.if_pred_taken, BTB_ON); end
    checks++; if (bus.if_pred_target !== (BTB_ON ? 32'h80 : 32'h0)) begin errors++; $display("FAIL btb_if_tgt got=%h exp=%h", bus.if_pred_target, (BTB_ON ? 32'h80 : 32'h0)); end
    checks++; if (bus.if_pc !== 32'h40) begin errors++; $display("FAIL btb_if_pc got=%h exp=%h", bus.if_pc, 32'h40); end
    redirect_to(32'h40);
    step(1'b0, BR, 1'b0);
    checks++; if (bus.imem_addr !== 32'h44) begin errors++; $display("FAIL btb_br_nt got=%h exp=%h", bus.imem_addr, 32'h44); end
    checks++; if (bus.if_pred_taken !== 1'b0) begin errors++; $display("FAIL btb_br_nt_pt got=%b exp=0", bus.if_pred_taken); end
    redirect_to(32'h40);
    step(1'b0, JAL, 1'b0);
    checks++; if (bus.imem_addr !== (BTB_ON ? 32'h80 : 32'h44)) begin errors++; $display("FAIL btb_jal got=%h exp=%h", bus.imem_addr, (BTB_ON ? 32'h80 : 32'h44)); end
    redirect_to(32'h440);
    step(1'b0, JAL, 1'b0);
    checks++; if (bus.imem_addr !== 32'h444) begin errors++; $display("FAIL btb_alias got=%h exp=%h", bus.imem_addr, 32'h444); end
    checks++; if (bus.if_pred_taken !== 1'b0) begin errors++; $display("FAIL btb_alias_pt got=%b exp=0", bus.if_pred_taken); end
    // lookup and rewrite of the same index in one cycle: old target wins this time
    redirect_to(32'h40);
    train(32'h40, 32'hC0, 1'b1);
    step(1'b0, JALR, 1'b0);
    checks++; if (bus.imem_addr !== (BTB_ON ? 32'h80 : 32'h44)) begin errors++; $display("FAIL btb_same_cycle got=%h exp=%h", bus.imem_addr, (BTB_ON ? 32'h80 : 32'h44)); end
    train(32'h40, 32'h200, 1'b0);
    step(1'b0, NOP, 1'b0);
    redirect_to(32'h40);
    step(1'b0, JAL, 1'b0);
    checks++; if (bus.imem_addr !== (BTB_ON ? 32'hC0 : 32'h44)) begin errors++; $display("FAIL btb_rewrite got=%h exp=%h", bus.imem_addr, (BTB_ON ? 32'hC0 : 32'h44)); end
  endtask

  task automatic test_stall();
    logic [31:0] e_pc, e_ifpc, inst;
    step(1'b0, NOP, 1'b0);
    e_pc = m_pc; e_ifpc = m_ifpc;
    for (int i = 0; i < 3; i++) begin
      inst = $urandom; inst[6:0] = 7'h13;
      step(1'b1, inst, 1'b0);
      checks++; if (bus.imem_addr !== e_pc) begin errors++; $display("FAIL stall_addr c=%0d got=%h exp=%h", i, bus.imem_addr, e_pc); end
      checks++; if (bus.if_pc !== e_ifpc) begin errors++; $display("FAIL stall_ifpc c=%0d got=%h exp=%h", i, bus.if_pc, e_ifpc); end
      checks++; if (bus.if_inst !== NOP || bus.if_valid !== 1'b1) begin errors++; $display("FAIL stall_ifid c=%0d got=%h/%b exp=%h/1", i, bus.if_inst, bus.if_valid, NOP); end
    end
    step(1'b0, NOP, 1'b0);
    checks++; if (bus.imem_addr !== e_pc + 32'd4) begin errors++; $display("FAIL stall_release got=%h exp=%h", bus.imem_addr, e_pc + 32'd4); end
    checks++; if (bus.if_pc !== e_pc) begin errors++; $display("FAIL stall_release_pc got=%h exp=%h", bus.if_pc, e_pc); end
  endtask

  task automatic test_wrap();
    bus.ex_valid = 1'b1; bus.ex_mispredict = 1'b1; bus.ex_is_cf = 1'b0;
    bus.ex_taken = 1'b0; bus.ex_pc = 32'hFFFF_FFF8;
    step(1'b0, NOP, 1'b0);
    checks++; if (bus.imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_pre got=%h exp=%h", bus.imem_addr, 32'hFFFF_FFFC); end
    step(1'b0, NOP, 1'b0);
    checks++; if (bus.imem_addr !== 32'h0) begin errors++; $display("FAIL wrap_zero got=%h exp=0", bus.imem_addr); end
    checks++; if (bus.if_pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_ifpc got=%h exp=%h", bus.if_pc, 32'hFFFF_FFFC); end
  endtask

  task automatic test_mid_reset();
    step(1'b1, NOP, 1'b0);
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++; if (bus.imem_addr !== RST_PC) begin errors++; $display("FAIL mrst_addr got=%h exp=%h", bus.imem_addr, RST_PC); end
    checks++; if (bus.if_valid !== 1'b0 || bus.if_inst !== NOP) begin errors++; $display("FAIL mrst_ifid got=%b/%h exp=0/%h", bus.if_valid, bus.if_inst, NOP); end
    @(posedge clk); #1;
    checks++; if (bus.imem_addr !== RST_PC) begin errors++; $display("FAIL mrst_hold got=%h exp=%h", bus.imem_addr, RST_PC); end
    rst_n = 1'b1;
    redirect_to(32'h40);
    step(1'b0, JAL, 1'b0);
    checks++; if (bus.imem_addr !== 32'h44) begin errors++; $display("FAIL mrst_btb_cleared got=%h exp=%h", bus.imem_addr, 32'h44); end
    checks++; if (bus.if_pred_taken !== 1'b0) begin errors++; $display("FAIL mrst_pt got=%b exp=0", bus.if_pred_taken); end
  endtask

  task automatic test_random();
    logic        st, ptk;
    logic [31:0] inst;
    int          r;
    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 3);
      inst = $urandom;
      case (r)
        0:       inst[6:0] = 7'h63;
        1:       inst[6:0] = 7'h6F;
        2:       inst[6:0] = 7'h67;
        default: inst[6:0] = 7'h13;
      endcase
      st  = ($urandom_range(0, 3) == 0);
      ptk = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 2) == 0) begin
        bus.ex_valid      = 1'b1;
        bus.ex_is_cf      = 1'($urandom_range(0, 1));
        bus.ex_taken      = ($urandom_range(0, 3) != 0);
        bus.ex_pc         = $urandom_range(0, 63) << 2;
        bus.ex_target     = $urandom_range(0, 255);
        bus.ex_mispredict = ($urandom_range(0, 2) == 0);
      end
      step(st, inst, ptk);
      checks++; if (bus.imem_addr !== m_pc) begin errors++; $display("FAIL rnd_addr n=%0d got=%h exp=%h", n, bus.imem_addr, m_pc); end
      checks++; if (bus.if_valid !== m_vld) begin errors++; $display("FAIL rnd_valid n=%0d got=%b exp=%b", n, bus.if_valid, m_vld); end
      if (m_vld) begin
        checks++; if (bus.if_pc !== m_ifpc) begin errors++; $display("FAIL rnd_ifpc n=%0d got=%h exp=%h", n, bus.if_pc, m_ifpc); end
      end
      checks++; if (bus.if_inst !== m_inst) begin errors++; $display("FAIL rnd_inst n=%0d got=%h exp=%h", n, bus.if_inst, m_inst); end
      checks++; if (bus.if_pred_taken !== m_pt) begin errors++; $display("FAIL rnd_pt n=%0d got=%b exp=%b", n, bus.if_pred_taken, m_pt); end
      checks++; if (bus.if_pred_target !== m_tgt) begin errors++; $display("FAIL rnd_tgt n=%0d got=%h exp=%h", n, bus.if_pred_target, m_tgt); end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    bus.stall = 1'b0; bus.imem_inst = NOP; bus.pred_taken = 1'b0;
    bus.ex_valid = 1'b0; bus.ex_is_cf = 1'b0; bus.ex_pc = 32'h0;
    bus.ex_taken = 1'b0; bus.ex_target = 32'h0; bus.ex_mispredict = 1'b0;
    model_reset();
    test_reset();
    test_redirect();
    test_btb();
    test_stall();
    test_wrap();
    test_mid_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
